// File: rtl/router_pkg.sv
// Shared types for the router read side: read FSM states, header field
// positions, the skid-buffer entry and the round-robin pick helper.
package router_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        HWAIT = 2'd2,
        PAY   = 2'd3
    } rd_state_e;

    localparam int HDR_LEN_MSB = 7;
    localparam int HDR_LEN_LSB = 2;

    typedef logic [1:0] port_id_t;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        port_id_t   port;
    } skid_entry_t;

    // First requester strictly after 'last' in cyclic order 0->1->2->0.
    function automatic port_id_t rr_pick(input logic [2:0] req, input port_id_t last);
        port_id_t p;
        rr_pick = last;
        for (int k = 3; k >= 1; k--) begin
            p = port_id_t'((int'(last) + k) % 3);
            if (req[p]) rr_pick = p;
        end
    endfunction

endpackage

// File: rtl/router_skid2.sv
// Two-entry FIFO between the FIFO read path and the downstream valid/ready port.
module router_skid2
    import router_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        push,
    input  skid_entry_t push_data,
    input  logic        pop,
    output skid_entry_t head,
    output logic [1:0]  count
);

    skid_entry_t mem [2];
    logic        wp, rp;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= push_data;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rp];

endmodule

// File: rtl/router_read_arbiter.sv
// Round-robin packet reader for the three router output FIFOs; holds the grant
// for a whole packet and streams bytes out through a 2-entry skid buffer.
module router_read_arbiter
    import router_pkg::*;
#(
    parameter int ABORT_LIMIT = 16,
    parameter int LEN_W       = 6
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       valid_out_0,
    input  logic       valid_out_1,
    input  logic       valid_out_2,
    input  logic [7:0] data_out_0,
    input  logic [7:0] data_out_1,
    input  logic [7:0] data_out_2,
    output logic       read_enb_0,
    output logic       read_enb_1,
    output logic       read_enb_2,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sop,
    output logic       m_eop,
    output logic [1:0] m_port,
    output logic       rd_busy,
    output logic       abort
);

    localparam int RW = LEN_W + 1;
    localparam int SW = $clog2(ABORT_LIMIT + 1);

    rd_state_e     state, state_nx;
    port_id_t      gnt, gnt_nx, last, last_nx, rd_port;
    logic [RW-1:0] rem, rem_nx;
    logic [SW-1:0] stall, stall_nx;
    logic          outst, rd_sop, rd_eop;
    logic          issue, iss_sop, iss_eop, abort_nx;
    logic [2:0]    vld, occ;
    logic [7:0]    din [3];
    logic          vld_g, pop, room;
    logic [1:0]    count;
    skid_entry_t   push_ent, head;

    assign vld    = {valid_out_2, valid_out_1, valid_out_0};
    assign din[0] = data_out_0;
    assign din[1] = data_out_1;
    assign din[2] = data_out_2;
    assign vld_g  = vld[gnt];

    // Occupancy after this cycle's pop, counting the read still in flight.
    assign pop  = m_valid & m_ready;
    assign occ  = {1'b0, count} + {2'b0, outst} - {2'b0, pop};
    assign room = occ < 3'd2;

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        last_nx  = last;
        rem_nx   = rem;
        stall_nx = stall;
        issue    = 1'b0;
        iss_sop  = 1'b0;
        iss_eop  = 1'b0;
        abort_nx = 1'b0;
        case (state)
            IDLE: if (|vld) begin
                gnt_nx   = rr_pick(vld, last);
                stall_nx = '0;
                state_nx = HDR;
            end
            HDR: if (vld_g && room) begin
                issue    = 1'b1;
                iss_sop  = 1'b1;
                state_nx = HWAIT;
            end
            HWAIT: begin
                // Header byte is on data_out this cycle: payload + parity remain.
                rem_nx   = RW'(din[gnt][HDR_LEN_LSB +: LEN_W]) + RW'(1);
                state_nx = PAY;
            end
            PAY: begin
                if (rem != '0) begin
                    if (vld_g && room) begin
                        issue   = 1'b1;
                        iss_eop = (rem == RW'(1));
                        rem_nx  = rem - RW'(1);
                    end
                end else if (!outst) begin
                    last_nx  = gnt;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Only an empty granted FIFO counts as a stall; backpressure just holds.
        if (issue) begin
            stall_nx = '0;
        end else if ((state == HDR || (state == PAY && rem != '0)) && !vld_g) begin
            if (stall == SW'(ABORT_LIMIT - 1)) begin
                abort_nx = 1'b1;
                stall_nx = '0;
                last_nx  = gnt;
                state_nx = IDLE;
            end else begin
                stall_nx = stall + SW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            gnt     <= '0;
            last    <= 2'd2;
            rem     <= '0;
            stall   <= '0;
            outst   <= 1'b0;
            rd_sop  <= 1'b0;
            rd_eop  <= 1'b0;
            rd_port <= '0;
            abort   <= 1'b0;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            last  <= last_nx;
            rem   <= rem_nx;
            stall <= stall_nx;
            outst <= issue;
            abort <= abort_nx;
            if (issue) begin
                rd_sop  <= iss_sop;
                rd_eop  <= iss_eop;
                rd_port <= gnt;
            end
        end
    end

    // The in-flight read lands regardless of state, so bytes survive an abort.
    assign push_ent = '{data: din[rd_port], sop: rd_sop, eop: rd_eop, port: rd_port};

    router_skid2 u_skid (
        .clock     (clock),
        .resetn    (resetn),
        .push      (outst),
        .push_data (push_ent),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign read_enb_0 = issue && (gnt == 2'd0);
    assign read_enb_1 = issue && (gnt == 2'd1);
    assign read_enb_2 = issue && (gnt == 2'd2);

    assign m_valid = (count != 2'd0);
    assign m_data  = m_valid ? head.data : '0;
    assign m_sop   = m_valid & head.sop;
    assign m_eop   = m_valid & head.eop;
    assign m_port  = m_valid ? head.port : '0;
    assign rd_busy = (state != IDLE);

endmodule

// File: tb/tb_router_read_arbiter.sv
// Self-checking bench: FIFO models feed the arbiter, a packet-level round-robin
// model predicts the downstream byte stream.
module tb_router_read_arbiter;
    import router_pkg::*;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic [1:0] port;
    } exp_t;

    typedef struct {
        int         port;
        logic [7:0] hdr;
        int         exp_reads;
        int         exp_bytes;
    } vec_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       valid_out_0 = 1'b0, valid_out_1 = 1'b0, valid_out_2 = 1'b0;
    logic [7:0] data_out_0 = '0, data_out_1 = '0, data_out_2 = '0;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [7:0] m_data;
    logic       m_valid, m_sop, m_eop, rd_busy, abort;
    logic       m_ready = 1'b1;
    logic [1:0] m_port;

    int tests = 0;
    int fails = 0;
    int rd_cnt [3];
    int out_cnt = 0;
    int abort_cnt = 0;
    int mdl_last = 2;

    logic [7:0] fq0[$], fq1[$], fq2[$];
    exp_t       exp_q[$], pend[$];
    vec_t       vecs[6];

    router_read_arbiter #(.ABORT_LIMIT(16), .LEN_W(6)) dut (
        .clock(clock), .resetn(resetn),
        .valid_out_0(valid_out_0), .valid_out_1(valid_out_1), .valid_out_2(valid_out_2),
        .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
        .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sop(m_sop), .m_eop(m_eop), .m_port(m_port),
        .rd_busy(rd_busy), .abort(abort)
    );

    always #5 clock = ~clock;

    function automatic int fifo_size(input int p);
        case (p)
            0:       return fq0.size();
            1:       return fq1.size();
            default: return fq2.size();
        endcase
    endfunction

    task automatic fifo_push(input int p, input logic [7:0] b);
        case (p)
            0:       fq0.push_back(b);
            1:       fq1.push_back(b);
            default: fq2.push_back(b);
        endcase
    endtask

    task automatic fifo_pop_to_dout(input int p);
        case (p)
            0:       data_out_0 = fq0.pop_front();
            1:       data_out_1 = fq1.pop_front();
            default: data_out_2 = fq2.pop_front();
        endcase
    endtask

    task automatic upd_valid();
        valid_out_0 = (fq0.size() != 0);
        valid_out_1 = (fq1.size() != 0);
        valid_out_2 = (fq2.size() != 0);
    endtask

    // One clock: sample/check at negedge, advance FIFO models just after posedge.
    task automatic tick();
        logic [2:0] rd;
        exp_t       e;
        @(negedge clock);
        rd = {read_enb_2, read_enb_1, read_enb_0};
        if (resetn) begin
            if ($countones(rd) > 1) begin
                fails++;
                $display("FAIL read_onehot: read_enb=%b, required at most one bit set", rd);
            end
            for (int p = 0; p < 3; p++) if (rd[p]) rd_cnt[p]++;
            if (abort) abort_cnt++;
            if (m_valid && m_ready) begin
                tests++;
                out_cnt++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL stream: unexpected byte data=%h port=%0d", m_data, m_port);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.d || m_sop !== e.sop || m_eop !== e.eop || m_port !== e.port) begin
                        fails++;
                        $display("FAIL stream: got data=%h sop=%b eop=%b port=%0d, required data=%h sop=%b eop=%b port=%0d",
                                 m_data, m_sop, m_eop, m_port, e.d, e.sop, e.eop, e.port);
                    end
                end
            end
        end
        @(posedge clock);
        #1;
        for (int p = 0; p < 3; p++) begin
            if (rd[p]) begin
                if (fifo_size(p) == 0) begin
                    fails++;
                    $display("FAIL fifo_underflow: read_enb_%0d on empty FIFO", p);
                end else begin
                    fifo_pop_to_dout(p);
                end
            end
        end
        upd_valid();
    endtask

    task automatic push_byte(input int p, input logic [7:0] b, input logic s, input logic e);
        fifo_push(p, b);
        pend.push_back('{d: b, sop: s, eop: e, port: 2'(p)});
    endtask

    // Header, hdr[7:2] random payload bytes, then an XOR parity byte.
    task automatic load_pkt(input int p, input logic [7:0] hdr);
        int         n;
        logic [7:0] par, b;
        n   = int'(hdr[7:2]);
        par = hdr;
        push_byte(p, hdr, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            b   = 8'($urandom);
            par = par ^ b;
            push_byte(p, b, 1'b0, 1'b0);
        end
        push_byte(p, par, 1'b0, 1'b1);
        upd_valid();
    endtask

    // Packet-level round robin over whatever is pending, starting after mdl_last.
    task automatic expect_batch();
        int   p, idx;
        bit   found;
        exp_t e;
        while (pend.size() != 0) begin
            found = 1'b0;
            p     = 0;
            for (int k = 1; k <= 3 && !found; k++) begin
                p = (mdl_last + k) % 3;
                foreach (pend[i]) if (pend[i].port == 2'(p)) found = 1'b1;
            end
            idx = -1;
            foreach (pend[i]) if (idx < 0 && pend[i].port == 2'(p)) idx = i;
            do begin
                e = pend[idx];
                pend.delete(idx);
                exp_q.push_back(e);
            end while (!e.eop);
            mdl_last = p;
        end
    endtask

    task automatic run_until_idle(input int budget, input bit rnd);
        int n;
        n = 0;
        do begin
            m_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            n++;
        end while (!(exp_q.size() == 0 && !rd_busy && !m_valid) && n < budget);
        m_ready = 1'b1;
        tests++;
        if (exp_q.size() != 0 || rd_busy || m_valid) begin
            fails++;
            $display("FAIL drain: after %0d cycles %0d bytes still expected, rd_busy=%b m_valid=%b, required 0/0/0",
                     n, exp_q.size(), rd_busy, m_valid);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        logic [16:0] v;
        v = {read_enb_2, read_enb_1, read_enb_0, m_data, m_valid, m_sop, m_eop, m_port, rd_busy, abort};
        tests++;
        if (v !== '0) begin
            fails++;
            $display("FAIL %s: outputs=%h, required all zero", name, v);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r0, r2, r4, tot;
        logic [7:0] h;

        vecs[0] = '{1, 8'h0D, 5, 5};
        vecs[1] = '{2, 8'h02, 2, 2};
        vecs[2] = '{0, 8'h05, 3, 3};
        vecs[3] = '{2, 8'h0B, 4, 4};
        vecs[4] = '{1, 8'h03, 2, 2};
        vecs[5] = '{0, 8'hFC, 65, 65};
        rd_cnt = '{default: 0};

        #3;
        check_outputs_zero("reset_state");
        @(posedge clock);
        #1;
        tick();
        resetn = 1'b1;

        // Single packets: read counts and byte counts per header length.
        foreach (vecs[i]) begin
            rd_cnt  = '{default: 0};
            out_cnt = 0;
            load_pkt(vecs[i].port, vecs[i].hdr);
            expect_batch();
            run_until_idle(300, 1'b0);
            tests++;
            if (rd_cnt[vecs[i].port] != vecs[i].exp_reads) begin
                fails++;
                $display("FAIL vec%0d_reads: got %0d, required %0d", i, rd_cnt[vecs[i].port], vecs[i].exp_reads);
            end
            tests++;
            if (out_cnt != vecs[i].exp_bytes) begin
                fails++;
                $display("FAIL vec%0d_bytes: got %0d, required %0d", i, out_cnt, vecs[i].exp_bytes);
            end
            tot = rd_cnt[0] + rd_cnt[1] + rd_cnt[2];
            tests++;
            if (tot != vecs[i].exp_reads) begin
                fails++;
                $display("FAIL vec%0d_other_port_reads: total %0d, required %0d", i, tot, vecs[i].exp_reads);
            end
        end

        // All three ports pending, twice: strict rotation, no interleaving.
        for (int r = 0; r < 2; r++) begin
            load_pkt(0, 8'h04);
            load_pkt(1, 8'h04);
            load_pkt(2, 8'h04);
            expect_batch();
            run_until_idle(100, 1'b0);
        end

        // Backpressure mid-payload: buffer fills, reads stop, nothing lost.
        rd_cnt  = '{default: 0};
        out_cnt = 0;
        load_pkt(1, 8'h30);
        expect_batch();
        n = 0;
        while (out_cnt < 4 && n < 50) begin
            tick();
            n++;
        end
        r0 = rd_cnt[1];
        m_ready = 1'b0;
        tick();
        tick();
        r2 = rd_cnt[1];
        tick();
        tick();
        r4 = rd_cnt[1];
        tests++;
        if (r4 != r2 || m_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold: reads in last 2 hold cycles %0d m_valid=%b, required 0 and 1", r4 - r2, m_valid);
        end
        tests++;
        if (r4 - r0 > 2) begin
            fails++;
            $display("FAIL bp_buffered: %0d reads during hold, required at most 2", r4 - r0);
        end
        run_until_idle(200, 1'b0);

        // Stall timeout: port 0 runs dry after 2 payload bytes of 10.
        abort_cnt = 0;
        h = 8'h28;
        fifo_push(0, h);
        exp_q.push_back('{d: h, sop: 1'b1, eop: 1'b0, port: 2'd0});
        for (int i = 0; i < 2; i++) begin
            h = 8'($urandom);
            fifo_push(0, h);
            exp_q.push_back('{d: h, sop: 1'b0, eop: 1'b0, port: 2'd0});
        end
        upd_valid();
        tick();
        tick();
        tick();
        mdl_last = 0;
        load_pkt(1, 8'h04);
        expect_batch();
        run_until_idle(150, 1'b0);
        tests++;
        if (abort_cnt != 1) begin
            fails++;
            $display("FAIL abort_pulse: got %0d pulses, required 1", abort_cnt);
        end

        // Randomised batches with random downstream backpressure.
        abort_cnt = 0;
        for (int r = 0; r < 6; r++) begin
            for (int p = 0; p < 3; p++) begin
                n = $urandom_range(0, 2);
                for (int k = 0; k < n; k++)
                    load_pkt(p, 8'($urandom_range(0, 7) << 2) | 8'($urandom_range(0, 3)));
            end
            expect_batch();
            run_until_idle(800, 1'b1);
        end
        tests++;
        if (abort_cnt != 0) begin
            fails++;
            $display("FAIL no_spurious_abort: got %0d pulses, required 0", abort_cnt);
        end

        // Asynchronous reset mid-payload, then priority restarts at port 0.
        out_cnt = 0;
        load_pkt(0, 8'h50);
        expect_batch();
        n = 0;
        while (out_cnt < 3 && n < 40) begin
            tick();
            n++;
        end
        #2;
        resetn = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        fq0.delete();
        fq1.delete();
        fq2.delete();
        pend.delete();
        exp_q.delete();
        data_out_0 = '0;
        data_out_1 = '0;
        data_out_2 = '0;
        upd_valid();
        mdl_last = 2;
        tick();
        tick();
        resetn = 1'b1;
        load_pkt(2, 8'h08);
        load_pkt(0, 8'h04);
        expect_batch();
        run_until_idle(100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
